mem_unloader: RTL and testbench
===============================

# mem_unloader

Reads a contiguous region of a router node's SRAM1024_32 on the system clock and streams it out as a serial bit stream with a valid/ready handshake. It is the read-back counterpart of the scan-chain memory loader: the loader serially writes the SRAM, and this block serially drains it for post-run result extraction and memory checks. It sits beside router2mem on the SRAM port and gets SRAM access through a request/grant pair, so packet traffic and unloading never collide.

## Interface
- `ADDR_W`, 10: SRAM address width.
- `DATA_W`, 32: SRAM word width; words are shifted MSB first.

- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: single-cycle request to begin an unload; sampled only in IDLE.
- `base_addr` in ADDR_W: first word address; captured on accepted `start`.
- `word_count` in ADDR_W+1: number of words, 0..1024; captured on accepted `start`.
- `mem_req` out 1: SRAM access request to the port arbiter.
- `mem_gnt` in 1: arbiter grant; the SRAM port is driven only while `mem_req && mem_gnt`.
- `CEN` out 1: SRAM chip enable, active-low.
- `WEN` out 1: SRAM write enable, active-low; tied high (read only).
- `A` out ADDR_W: SRAM address.
- `Q` in DATA_W: SRAM read data; valid in the cycle after the read cycle.
- `scan_out` out 1: serial data bit.
- `scan_valid` out 1: `scan_out` holds a valid bit.
- `scan_ready` in 1: consumer accepts a bit when `scan_valid && scan_ready`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: single-cycle pulse when an unload completes.

## Operation
- FSM states: IDLE, REQ, READ, CAPT, SHIFT, DONE.
- IDLE to REQ: on `start` with `word_count` != 0. Latch `base_addr` into the address counter and `word_count` into the remaining counter.
- IDLE to DONE: on `start` with `word_count` == 0. No SRAM access.
- REQ: assert `mem_req`. Go to READ when `mem_gnt` is high.
- READ: `CEN`=0 and `A` = address counter, for one cycle. `mem_req` stays high. Go to CAPT.
- CAPT: load `Q` into the DATA_W shift register. Bit counter = DATA_W-1. Drop `mem_req`. Go to SHIFT.
- SHIFT:
  - `scan_valid`=1 and `scan_out` = shift register MSB.
  - On each handshake: shift left and decrement the bit counter.
  - On the handshake of the last bit: decrement remaining words and increment the address, wrapping 1023 to 0.
  - If words remain, go to REQ; otherwise go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` is ignored outside IDLE.
- A grant is ignored when `mem_req` is low.
- Losing `mem_gnt` during READ is an arbiter protocol violation. The block still completes that read.
- When `scan_ready` is low, `scan_out` and `scan_valid` hold stable.
- Reset values:
  - `mem_req`=0, `CEN`=1, `WEN`=1, `A`=0.
  - `scan_out`=0, `scan_valid`=0, `busy`=0, `done`=0.
  - FSM in IDLE, all counters 0.
- Reset mid-unload aborts immediately: the FSM returns to IDLE, there is no `done` pulse, and the remaining words are discarded.

## Timing
- All outputs are registered, except `CEN`, `A` and `mem_req`, which are decoded from the registered state and address.
- `start` in cycle 0 gives REQ in cycle 1.
- With grant already high: READ in cycle 2, CAPT in cycle 3, first bit valid in cycle 4.
- Per-word overhead between the last bit of word n and the first bit of word n+1 is 3 cycles (REQ, READ, CAPT) plus any grant wait.
- With `scan_ready` held high and grant immediate, a full word takes 35 cycles from REQ to the last handshake.
- `done` asserts the cycle after the final bit handshake.
- `busy` falls in the cycle after `done`.

## Configuration
- `MEM_UNLOADER_PARITY_EN` defined:
  - After bit 0 of each word, one extra bit is shifted: the even parity (XOR) of the 32 data bits.
  - Each word is 33 handshakes, and the bit counter starts at DATA_W.
- Undefined: exactly DATA_W bits per word, with no parity logic.

## Test plan
- Reset values: hold `reset` high with random inputs. All outputs must match the reset values above. Then `start`=1, `base_addr`=5, `word_count`=1, `mem_gnt`=1, `Q`=32'hDEADBEEF on the read: `A`=5 in cycle 2, bits 1101_1110… are shifted out, `done` pulses once.
- Two words, stalled grant and consumer: `base_addr`=10, `word_count`=2, `mem_gnt` low for 4 cycles then high, `scan_ready` toggling 1/0, SRAM model holding 32'h00000001 and 32'h80000000. The stream must be 31 zeros, 1, then 1, 31 zeros. `scan_out` must be stable through stalls, and `CEN` must be low for exactly 2 cycles total.
- Address wrap: `base_addr`=1023, `word_count`=2. Reads must hit `A`=1023 then `A`=0.
- Zero count and start while busy: `word_count`=0 gives a `done` pulse 1 cycle after `start` with `CEN` never low. A second `start` issued mid-SHIFT must be ignored; the word count and addresses are unchanged.
- Reset mid-unload: assert `reset` after 10 bits of word 0 of a 3-word unload. Outputs return to reset values asynchronously and no `done` pulse occurs. A fresh unload after reset must work normally.
- Parity (with `MEM_UNLOADER_PARITY_EN`): word 32'h00000007 gives 33 bits, with the last bit = 1. Word 32'h00000003 gives a last bit of 0.

Source files
------------

// File: rtl/mem_unloader_if.sv
// SRAM-port and serial-stream bundle for mem_unloader.
// master: the unloader side; slave: arbiter/SRAM/consumer side.
interface mem_unloader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              mem_req;
  logic              mem_gnt;
  logic              CEN;
  logic              WEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] Q;
  logic              scan_out;
  logic              scan_valid;
  logic              scan_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, base_addr, word_count, mem_gnt, Q, scan_ready,
    output mem_req, CEN, WEN, A, scan_out, scan_valid, busy, done
  );

  modport slave (
    output start, base_addr, word_count, mem_gnt, Q, scan_ready,
    input  mem_req, CEN, WEN, A, scan_out, scan_valid, busy, done
  );
endinterface

// File: rtl/mem_unloader.sv
// Drains a contiguous SRAM region as an MSB-first serial stream (valid/ready).
// Optional MEM_UNLOADER_PARITY_EN appends an even-parity bit after each word.
module mem_unloader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic           i_clock,
  input  logic           i_reset,
  mem_unloader_if.master bus
);
  localparam int CNT_W = $clog2(DATA_W + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_READ, S_CAPT, S_SHIFT, S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remain;
  logic [CNT_W-1:0]  r_bitcnt;
  logic [DATA_W-1:0] r_shreg;
  logic              r_sv;
  logic              r_busy;
  logic              r_done;
  logic              w_fill;
  logic              w_hs;

`ifdef MEM_UNLOADER_PARITY_EN
  localparam logic [CNT_W-1:0] BIT_TOP = CNT_W'(DATA_W);
  logic r_par;
  // Parity is shifted in behind the data so it reaches the MSB after bit 0.
  assign w_fill = r_par;
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)              r_par <= 1'b0;
    else if (r_state == S_CAPT) r_par <= ^bus.Q;
  end
`else
  localparam logic [CNT_W-1:0] BIT_TOP = CNT_W'(DATA_W - 1);
  assign w_fill = 1'b0;
`endif

  assign w_hs = r_sv && bus.scan_ready;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      r_sv     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            if (bus.word_count != '0) begin
              r_addr   <= bus.base_addr;
              r_remain <= bus.word_count;
              r_state  <= S_REQ;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_gnt) r_state <= S_READ;
        end
        // Read completes even if the grant drops here; the arbiter owns that fault.
        S_READ: r_state <= S_CAPT;
        S_CAPT: begin
          r_shreg  <= bus.Q;
          r_bitcnt <= BIT_TOP;
          r_sv     <= 1'b1;
          r_state  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_hs) begin
            r_shreg <= {r_shreg[DATA_W-2:0], w_fill};
            if (r_bitcnt == '0) begin
              r_sv     <= 1'b0;
              r_addr   <= r_addr + ADDR_W'(1);
              r_remain <= r_remain - (ADDR_W+1)'(1);
              if (r_remain == (ADDR_W+1)'(1)) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_state <= S_REQ;
              end
            end else begin
              r_bitcnt <= r_bitcnt - CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req    = (r_state == S_REQ) || (r_state == S_READ);
  assign bus.CEN        = (r_state != S_READ);
  assign bus.WEN        = 1'b1;
  assign bus.A          = r_addr;
  assign bus.scan_out   = r_shreg[DATA_W-1];
  assign bus.scan_valid = r_sv;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule

// File: tb/tb_mem_unloader.sv
// Scoreboard bench for mem_unloader: expected bits/addresses queued at start, checked on handshakes/reads.
module tb_mem_unloader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_unloader_if #(.ADDR_W(10), .DATA_W(32)) bus();
  mem_unloader #(.ADDR_W(10), .DATA_W(32)) dut (.i_clock(clk), .i_reset(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cen_cnt = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int rdy_mode = 2;
  bit exp_bits[$];
  logic [9:0] exp_addr[$];
  logic [31:0] mem [0:1023];
  bit stall_prev = 1'b0;
  logic prev_out = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SRAM model: one-cycle read latency
  always @(posedge clk) if (!bus.CEN) bus.Q <= mem[bus.A];

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.scan_ready = 1'b1;
      1:       bus.scan_ready = ~bus.scan_ready;
      default: bus.scan_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev)
        chk("stall_hold", {62'd0, bus.scan_valid, bus.scan_out}, {62'd0, 1'b1, prev_out});
      if (bus.scan_valid && bus.scan_ready) begin
        hs_cnt++;
        if (exp_bits.size() == 0) chk("extra_bit", 64'(exp_bits.size()), 64'd1);
        else chk("bit", 64'(bus.scan_out), 64'(exp_bits.pop_front()));
      end
      if (!bus.CEN) begin
        cen_cnt++;
        chk("wen", 64'(bus.WEN), 64'd1);
        if (exp_addr.size() == 0) chk("extra_read", 64'(exp_addr.size()), 64'd1);
        else chk("addr", 64'(bus.A), 64'(exp_addr.pop_front()));
      end
      if (bus.done) done_cnt++;
      stall_prev = bus.scan_valid && !bus.scan_ready;
      prev_out   = bus.scan_out;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push_word(input logic [9:0] a, input logic [31:0] w);
    mem[a] = w;
    exp_addr.push_back(a);
    for (int i = 31; i >= 0; i--) exp_bits.push_back(w[i]);
`ifdef MEM_UNLOADER_PARITY_EN
    exp_bits.push_back(^w);
`endif
  endtask

  task automatic kick(input logic [9:0] b, input logic [10:0] c);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = b; bus.word_count = c;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      chk("busy_at_done", 64'(bus.busy), 64'd1);
      @(negedge clk);
      chk("done_one_cycle", 64'(bus.done), 64'd0);
      chk("busy_fall", 64'(bus.busy), 64'd0);
    end
  endtask

  task automatic chk_rst_outs(input string tag);
    chk(tag, {47'd0, bus.mem_req, bus.CEN, bus.WEN, bus.A, bus.scan_out, bus.scan_valid, bus.busy, bus.done},
        {47'd0, 1'b0, 1'b1, 1'b1, 10'd0, 4'b0000});
  endtask

  task automatic chk_queues(input string tag);
    chk({tag, "_bits_left"}, 64'(exp_bits.size()), 64'd0);
    chk({tag, "_reads_left"}, 64'(exp_addr.size()), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0; bus.mem_gnt = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) ^ 32'h5A5A_0000;

    // reset with random inputs
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.start = 1'($urandom); bus.base_addr = 10'($urandom);
      bus.word_count = 11'($urandom); bus.mem_gnt = 1'($urandom);
      @(negedge clk);
      chk_rst_outs("reset_vals");
    end
    @(posedge clk); #1;
    bus.start = 1'b0; rdy_mode = 0; bus.mem_gnt = 1'b1;
    rst = 1'b0;

    // single word, exact cycle timing
    push_word(10'd5, 32'hDEADBEEF);
    kick(10'd5, 11'd1);
    @(negedge clk);
    chk("c1_req", {61'd0, bus.mem_req, bus.CEN, bus.busy}, {61'd0, 3'b111});
    @(negedge clk);
    chk("c2_read", {52'd0, bus.mem_req, bus.CEN, bus.A}, {52'd0, 1'b1, 1'b0, 10'd5});
    @(negedge clk);
    chk("c3_capt", {61'd0, bus.mem_req, bus.CEN, bus.scan_valid}, {61'd0, 3'b010});
    @(negedge clk);
    chk("c4_first_bit", {62'd0, bus.scan_valid, bus.scan_out}, {62'd0, 2'b11});
    done_cnt = 0;
    wait_done(200);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk_queues("t1");

    // two words, stalled grant, toggling consumer
    cen_cnt = 0;
    bus.mem_gnt = 1'b0;
    rdy_mode = 1;
    push_word(10'd10, 32'h0000_0001);
    push_word(10'd11, 32'h8000_0000);
    kick(10'd10, 11'd2);
    repeat (3) @(posedge clk);
    #1 bus.mem_gnt = 1'b1;
    wait_done(1000);
    rdy_mode = 0;
    chk("t2_cen_cycles", 64'(cen_cnt), 64'd2);
    chk_queues("t2");

    // address wrap
    push_word(10'd1023, 32'hA5A5_5A5A);
    push_word(10'd0, 32'h1234_5678);
    kick(10'd1023, 11'd2);
    wait_done(500);
    chk_queues("t3");

    // zero count
    cen_cnt = 0;
    kick(10'd7, 11'd0);
    wait_done(1);
    chk("t4_zero_no_read", 64'(cen_cnt), 64'd0);

    // start while busy is ignored
    done_cnt = 0;
    push_word(10'd20, 32'hCAFE_F00D);
    push_word(10'd21, 32'h0F0F_1234);
    kick(10'd20, 11'd2);
    for (int i = 0; i < 50 && !bus.scan_valid; i++) @(negedge clk);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = 10'd100; bus.word_count = 11'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(500);
    chk("t4_busy_start_done_cnt", 64'(done_cnt), 64'd1);
    chk_queues("t4");

    // reset mid-unload
    done_cnt = 0;
    hs_cnt = 0;
    push_word(10'd40, 32'h1357_9BDF);
    push_word(10'd41, 32'h2468_ACE0);
    push_word(10'd42, 32'hFFFF_0000);
    kick(10'd40, 11'd3);
    for (int i = 0; i < 200 && hs_cnt < 10; i++) @(negedge clk);
    chk("t5_reached_10_bits", 64'(hs_cnt), 64'd10);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_rst_outs("t5_async_reset");
    exp_bits.delete();
    exp_addr.delete();
    repeat (3) @(negedge clk);
    chk_rst_outs("t5_reset_hold");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_done", 64'(done_cnt), 64'd0);
    push_word(10'd50, 32'h0BAD_CAFE);
    kick(10'd50, 11'd1);
    wait_done(200);
    chk_queues("t5_fresh");

`ifdef MEM_UNLOADER_PARITY_EN
    // parity bit: odd-weight word then even-weight word
    hs_cnt = 0;
    push_word(10'd60, 32'h0000_0007);
    push_word(10'd61, 32'h0000_0003);
    kick(10'd60, 11'd2);
    wait_done(500);
    chk("t6_parity_handshakes", 64'(hs_cnt), 64'd66);
    chk_queues("t6");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
